mem_stage_ctrl: RTL and testbench

//  MEM-stage controller between the EX/MEM pipeline register and the memory

---
 rtl/mem_stage_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// ---------------------------------------------------------------------------
// mem_stage_ctrl
//   MEM-stage controller. It sits between the EX/MEM pipeline register and a
//   stalling data memory, and it owns the MEM/WB register. Each instruction
//   issues one load or store. While the memory stalls, the controller holds
//   that access stable and freezes the upstream stages.
//
//   Optional feature: define STALL_TIMEOUT_EN to bound the WAIT state. When
//   the bound is hit, the controller sets a sticky Err flag, abandons the
//   access and writes a bubble into MEM/WB. Without the macro, WAIT is
//   unbounded and Err is tied low.
// ---------------------------------------------------------------------------
module mem_stage_ctrl #(
    parameter int DW      = 16,
    parameter int RW      = 3,
    parameter int TIMEOUT = 64
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          ReqValid,
    input  logic          ReqRead,
    input  logic          ReqWrite,
    input  logic [DW-1:0] ReqAddr,
    input  logic [DW-1:0] ReqData,
    input  logic [RW-1:0] ReqDest,
    input  logic          ReqRegWrite,
    input  logic          Flush,
    output logic [DW-1:0] MemAddr,
    output logic [DW-1:0] MemData,
    output logic          MemRead,
    output logic          MemWrite,
    input  logic [DW-1:0] MemReadData,
    input  logic          MemStall,
    output logic          PipeStall,
    output logic          WbValid,
    output logic [DW-1:0] WbData,
    output logic [RW-1:0] WbDest,
    output logic          WbRegWrite,
    output logic [15:0]   StallCount,
    output logic          Err
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t        state_q;
    logic          squash_q;

    // Copy of the access that is held while the memory stalls.
    logic [DW-1:0] addr_q;
    logic [DW-1:0] data_q;
    logic          rd_q;
    logic          wr_q;
    logic [RW-1:0] dest_q;
    logic          regwr_q;

    logic          wb_valid_q;
    logic [DW-1:0] wb_data_q;
    logic [RW-1:0] wb_dest_q;
    logic          wb_regwr_q;

    logic [15:0]   stall_cnt_q;
    logic [15:0]   stall_cnt_d;

    logic          issue_rd;
    logic          issue_wr;
    logic          issue;
    logic          tmo_fire;

    // When a read and a write arrive together, the write wins. A flushed
    // instruction never reaches the memory.
    assign issue_rd = ReqValid & ReqRead & ~ReqWrite & ~Flush;
    assign issue_wr = ReqValid & ReqWrite & ~Flush;
    assign issue    = issue_rd | issue_wr;

`ifdef STALL_TIMEOUT_EN
    logic [15:0] tmo_cnt_q;
    logic        err_q;

    // The limit is hit on the TIMEOUT-th consecutive stalled WAIT cycle.
    assign tmo_fire = (state_q == S_WAIT) && MemStall && (tmo_cnt_q == 16'(TIMEOUT - 1));

    // Count stalled WAIT cycles; Err is sticky until reset.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (state_q != S_WAIT || tmo_fire) begin
                tmo_cnt_q <= '0;
            end else if (MemStall) begin
                tmo_cnt_q <= tmo_cnt_q + 16'd1;
            end
            if (tmo_fire) begin
                err_q <= 1'b1;
            end
        end
    end

    assign Err = err_q;
`else
    // WAIT has no bound in this build, so TIMEOUT only needs to be legal.
    if (TIMEOUT < 1) begin : g_timeout_unused
    end

    assign tmo_fire = 1'b0;
    assign Err      = 1'b0;
`endif

    // Memory-side drive: taken straight from EX/MEM in IDLE and from the held
    // copy in WAIT. Reset forces the access strobes and PipeStall low.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        MemAddr   = ReqAddr;
        MemData   = ReqData;
        MemRead   = issue_rd;
        MemWrite  = issue_wr;
        PipeStall = issue & MemStall;
        if (state_q == S_WAIT) begin
            MemAddr   = addr_q;
            MemData   = data_q;
            MemRead   = rd_q;
            MemWrite  = wr_q;
            // On a timeout cycle, upstream is released and the op is dropped.
            PipeStall = MemStall & ~tmo_fire;
        end
        if (Rst) begin
            MemRead   = 1'b0;
            MemWrite  = 1'b0;
            PipeStall = 1'b0;
        end
    end

    // Control FSM together with the held access and the MEM/WB register.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            // NOTE: all state updates are non-blocking, so every register sees
            // the values from before the edge.
            state_q    <= S_IDLE;
            squash_q   <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            dest_q     <= '0;
            regwr_q    <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_dest_q  <= '0;
            wb_regwr_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (issue && MemStall) begin
                        addr_q     <= ReqAddr;
                        data_q     <= ReqData;
                        rd_q       <= issue_rd;
                        wr_q       <= issue_wr;
                        dest_q     <= ReqDest;
                        regwr_q    <= ReqRegWrite;
                        squash_q   <= 1'b0;
                        wb_valid_q <= 1'b0;
                        wb_regwr_q <= 1'b0;
                        state_q    <= S_WAIT;
                    end else begin
                        wb_valid_q <= ReqValid & ~Flush;
                        wb_data_q  <= issue_rd ? MemReadData : ReqAddr;
                        wb_dest_q  <= ReqDest;
                        wb_regwr_q <= ReqValid & ~Flush & ReqRegWrite;
                    end
                end
                S_WAIT: begin
                    if (tmo_fire) begin
                        squash_q   <= 1'b0;
                        wb_valid_q <= 1'b0;
                        wb_regwr_q <= 1'b0;
                        state_q    <= S_IDLE;
                    end else if (!MemStall) begin
                        wb_valid_q <= ~(squash_q | Flush);
                        wb_data_q  <= rd_q ? MemReadData : addr_q;
                        wb_dest_q  <= dest_q;
                        wb_regwr_q <= regwr_q & ~(squash_q | Flush);
                        squash_q   <= 1'b0;
                        state_q    <= S_IDLE;
                    end else begin
                        wb_valid_q <= 1'b0;
                        wb_regwr_q <= 1'b0;
                        if (Flush) begin
                            squash_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Saturating count of frozen cycles.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (PipeStall && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign WbValid    = wb_valid_q;
    assign WbData     = wb_data_q;
    assign WbDest     = wb_dest_q;
    assign WbRegWrite = wb_regwr_q;
    assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_stage_ctrl
//   Directed bench for mem_stage_ctrl. A table of single-cycle, no-stall
//   vectors is followed by hand-written sequences that cover load and store
//   misses, a flush in WAIT, a reset in the middle of a stall and, when
//   STALL_TIMEOUT_EN is defined, the stall timeout.
// ---------------------------------------------------------------------------
module tb_mem_stage_ctrl;

    localparam int DW = 16;
    localparam int RW = 3;

    logic          Clk = 1'b0;
    logic          Rst;
    logic          ReqValid, ReqRead, ReqWrite, ReqRegWrite, Flush;
    logic [DW-1:0] ReqAddr, ReqData, MemReadData;
    logic [RW-1:0] ReqDest;
    logic          MemStall;
    logic [DW-1:0] MemAddr, MemData, WbData;
    logic          MemRead, MemWrite, PipeStall, WbValid, WbRegWrite, Err;
    logic [RW-1:0] WbDest;
    logic [15:0]   StallCount;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    mem_stage_ctrl #(.DW(DW), .RW(RW), .TIMEOUT(4)) dut (
        .Clk(Clk), .Rst(Rst),
        .ReqValid(ReqValid), .ReqRead(ReqRead), .ReqWrite(ReqWrite),
        .ReqAddr(ReqAddr), .ReqData(ReqData), .ReqDest(ReqDest),
        .ReqRegWrite(ReqRegWrite), .Flush(Flush),
        .MemAddr(MemAddr), .MemData(MemData), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemReadData(MemReadData), .MemStall(MemStall), .PipeStall(PipeStall),
        .WbValid(WbValid), .WbData(WbData), .WbDest(WbDest), .WbRegWrite(WbRegWrite),
        .StallCount(StallCount), .Err(Err)
    );

    typedef struct {
        logic          valid, rd, wr, regwr, flush;
        logic [DW-1:0] addr, data, rdata;
        logic [RW-1:0] dest;
        logic          e_mrd, e_mwr;
        logic          e_wbv, e_wbrw;
        logic [DW-1:0] e_wbd;
        logic [RW-1:0] e_dest;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic rd, input logic wr, input logic [DW-1:0] a,
                         input logic [DW-1:0] d, input logic [RW-1:0] dst, input logic rw,
                         input logic fl, input logic [DW-1:0] rdat, input logic st);
        ReqValid = v; ReqRead = rd; ReqWrite = wr; ReqAddr = a; ReqData = d;
        ReqDest = dst; ReqRegWrite = rw; Flush = fl; MemReadData = rdat; MemStall = st;
    endtask

    task automatic idle_inputs();
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 16'h0, 1'b0);
    endtask

    initial begin
        // Single-cycle vectors, all with MemStall=0.
        //            v     rd    wr    rw    fl    addr      data      rdata     dest  mrd   mwr   wbv   wbrw  wbd       dest
        vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000, 16'hBEEF, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 16'hBEEF, 3'd3};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1111, 16'h0000, 16'hAAAA, 3'd5, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1111, 3'd5};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h1234, 16'h0000, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0010, 3'd0};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0020, 16'h5678, 16'hCCCC, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0020, 3'd1};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0030, 16'h0000, 16'hDDDD, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0030, 3'd2};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0050, 16'h0000, 16'hEEEE, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0050, 3'd7};

        // Reset state; a live load during reset must not reach the memory.
        Rst = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 16'h0040, 16'h0, 3'd1, 1'b1, 1'b0, 16'h0, 1'b1);
        #12;
        check("rst_memread", 32'(MemRead), 32'h0);
        check("rst_pipestall", 32'(PipeStall), 32'h0);
        idle_inputs();
        @(negedge Clk);
        Rst = 1'b0;
        #1;
        check("rst_wbvalid", 32'(WbValid), 32'h0);
        check("rst_wbdata", 32'(WbData), 32'h0);
        check("rst_wbregwrite", 32'(WbRegWrite), 32'h0);
        check("rst_stallcount", 32'(StallCount), 32'h0);
        check("rst_err", 32'(Err), 32'h0);

        // Table-driven single-cycle accesses.
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            drive(vecs[i].valid, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data,
                  vecs[i].dest, vecs[i].regwr, vecs[i].flush, vecs[i].rdata, 1'b0);
            #1;
            check($sformatf("v%0d_memread", i), 32'(MemRead), 32'(vecs[i].e_mrd));
            check($sformatf("v%0d_memwrite", i), 32'(MemWrite), 32'(vecs[i].e_mwr));
            check($sformatf("v%0d_memaddr", i), 32'(MemAddr), 32'(vecs[i].addr));
            check($sformatf("v%0d_pipestall", i), 32'(PipeStall), 32'h0);
            @(posedge Clk);
            #1;
            check($sformatf("v%0d_wbvalid", i), 32'(WbValid), 32'(vecs[i].e_wbv));
            check($sformatf("v%0d_wbregwrite", i), 32'(WbRegWrite), 32'(vecs[i].e_wbrw));
            if (vecs[i].e_wbv) begin
                check($sformatf("v%0d_wbdata", i), 32'(WbData), 32'(vecs[i].e_wbd));
                check($sformatf("v%0d_wbdest", i), 32'(WbDest), 32'(vecs[i].e_dest));
            end
        end
        check("tbl_stallcount", 32'(StallCount), 32'h0);

        // T2: load miss with three stall cycles. Inputs are scrambled while
        // in WAIT, so the held copy must drive the memory.
        for (int c = 0; c < 3; c++) begin
            @(negedge Clk);
            if (c == 0) drive(1'b1, 1'b1, 1'b0, 16'h0040, 16'h0, 3'd3, 1'b1, 1'b0, 16'h0, 1'b1);
            else        drive(1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h0, 3'd6, 1'b0, 1'b0, 16'h0, 1'b1);
            #1;
            check($sformatf("t2_c%0d_pipestall", c), 32'(PipeStall), 32'h1);
            check($sformatf("t2_c%0d_memread", c), 32'(MemRead), 32'h1);
            check($sformatf("t2_c%0d_memaddr", c), 32'(MemAddr), 32'h0040);
            @(posedge Clk);
            #1;
            check($sformatf("t2_c%0d_bubble", c), 32'(WbValid), 32'h0);
        end
        @(negedge Clk);
        MemStall = 1'b0;
        MemReadData = 16'hBEEF;
        #1;
        check("t2_done_pipestall", 32'(PipeStall), 32'h0);
        check("t2_done_memaddr", 32'(MemAddr), 32'h0040);
        @(posedge Clk);
        #1;
        check("t2_wbvalid", 32'(WbValid), 32'h1);
        check("t2_wbdata", 32'(WbData), 32'hBEEF);
        check("t2_wbdest", 32'(WbDest), 32'h3);
        check("t2_stallcount", 32'(StallCount), 32'd3);

        // T3: store with two stall cycles; MemWrite/MemData held for 3 cycles.
        for (int c = 0; c < 3; c++) begin
            @(negedge Clk);
            drive(1'b1, 1'b0, 1'b1, 16'h0010, 16'h1234, 3'd0, 1'b0, 1'b0, 16'h0, (c < 2));
            #1;
            check($sformatf("t3_c%0d_memwrite", c), 32'(MemWrite), 32'h1);
            check($sformatf("t3_c%0d_memdata", c), 32'(MemData), 32'h1234);
            check($sformatf("t3_c%0d_pipestall", c), 32'(PipeStall), (c < 2) ? 32'h1 : 32'h0);
        end
        @(posedge Clk);
        #1;
        check("t3_wbvalid", 32'(WbValid), 32'h1);
        check("t3_wbregwrite", 32'(WbRegWrite), 32'h0);
        check("t3_wbdata", 32'(WbData), 32'h0010);
        check("t3_stallcount", 32'(StallCount), 32'd5);

        // T4: flush pulsed in the 2nd stall cycle of a load miss.
        for (int c = 0; c < 4; c++) begin
            @(negedge Clk);
            drive(1'b1, 1'b1, 1'b0, 16'h0060, 16'h0, 3'd4, 1'b1, (c == 1), 16'h9999, (c < 3));
            #1;
            check($sformatf("t4_c%0d_memread", c), 32'(MemRead), 32'h1);
        end
        @(posedge Clk);
        #1;
        check("t4_wbvalid", 32'(WbValid), 32'h0);
        check("t4_wbregwrite", 32'(WbRegWrite), 32'h0);
        check("t4_stallcount", 32'(StallCount), 32'd8);
        // Back-to-back hit right after WAIT exits: squash must be gone.
        @(negedge Clk);
        drive(1'b1, 1'b1, 1'b0, 16'h0070, 16'h0, 3'd2, 1'b1, 1'b0, 16'h4242, 1'b0);
        @(posedge Clk);
        #1;
        check("t4_next_wbvalid", 32'(WbValid), 32'h1);
        check("t4_next_wbdata", 32'(WbData), 32'h4242);

        // T5: asynchronous reset in the middle of a stall.
        for (int c = 0; c < 2; c++) begin
            @(negedge Clk);
            drive(1'b1, 1'b1, 1'b0, 16'h0080, 16'h0, 3'd5, 1'b1, 1'b0, 16'h0, 1'b1);
        end
        @(posedge Clk);
        #1;
        check("t5_pre_stallcount", 32'(StallCount), 32'd10);
        check("t5_pre_memread", 32'(MemRead), 32'h1);
        #2;
        Rst = 1'b1;
        #1;
        check("t5_memread", 32'(MemRead), 32'h0);
        check("t5_pipestall", 32'(PipeStall), 32'h0);
        check("t5_wbvalid", 32'(WbValid), 32'h0);
        check("t5_stallcount", 32'(StallCount), 32'h0);
        @(negedge Clk);
        idle_inputs();
        Rst = 1'b0;
        @(posedge Clk);
        #1;
        check("t5_after_wbvalid", 32'(WbValid), 32'h0);
        check("t5_after_memread", 32'(MemRead), 32'h0);

`ifdef STALL_TIMEOUT_EN
        // T6: memory stuck in stall; Err after 4 WAIT cycles, sticky until reset.
        @(negedge Clk);
        drive(1'b1, 1'b1, 1'b0, 16'h0090, 16'h0, 3'd1, 1'b1, 1'b0, 16'h0, 1'b1);
        @(posedge Clk);
        for (int c = 0; c < 4; c++) begin
            #1;
            check($sformatf("t6_w%0d_err", c), 32'(Err), 32'h0);
            @(posedge Clk);
        end
        #1;
        check("t6_err", 32'(Err), 32'h1);
        check("t6_wbvalid", 32'(WbValid), 32'h0);
        @(negedge Clk);
        idle_inputs();
        #1;
        check("t6_idle_memread", 32'(MemRead), 32'h0);
        repeat (3) @(posedge Clk);
        #1;
        check("t6_sticky", 32'(Err), 32'h1);
        Rst = 1'b1;
        #1;
        check("t6_rst_clear", 32'(Err), 32'h0);
        @(negedge Clk);
        Rst = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
